// File: rtl/seq_mag_compare.sv
// Multi-cycle cascadable magnitude comparator.
// Scans operands CHUNK bits per cycle from the MSB chunk down.
module seq_mag_compare #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_mode,
    input  logic [2:0]       casc_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       f_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic             sgn_q, sgn_n;
    logic [2:0]       casc_q, casc_n;
    logic [IW-1:0]    idx, idx_n;
    logic             dec_q, dec_n;
    logic [1:0]       res_q, res_n;
    logic [2:0]       f_n;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] ca, cb;
    logic             hit_gt, hit_lt, dec_now;
    logic [1:0]       res_now;
    logic [2:0]       casc_res;

    // State and datapath registers; reset aborts any compare in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            casc_q <= '0;
            idx    <= '0;
            dec_q  <= 1'b0;
            res_q  <= '0;
            f_out  <= '0;
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            b_q    <= b_n;
            sgn_q  <= sgn_n;
            casc_q <= casc_n;
            idx    <= idx_n;
            dec_q  <= dec_n;
            res_q  <= res_n;
            f_out  <= f_n;
        end
    end

    // Current chunk compare; signed mode flips the sign bit of the MSB chunk
    always_comb begin
        a_sh = a_q >> (idx * CHUNK);
        b_sh = b_q >> (idx * CHUNK);
        ca   = a_sh[CHUNK-1:0];
        cb   = b_sh[CHUNK-1:0];
        if (sgn_q && idx == LAST) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        hit_gt  = ca > cb;
        hit_lt  = ca < cb;
        dec_now = dec_q | hit_gt | hit_lt;
        res_now = dec_q ? res_q : {hit_gt, hit_lt};
        case (casc_q)
            3'b100:  casc_res = 3'b100;
            3'b010:  casc_res = 3'b010;
            default: casc_res = 3'b001;
        endcase
    end

    // Next-state logic: accept in IDLE/DONE, scan in CMP
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        sgn_n   = sgn_q;
        casc_n  = casc_q;
        idx_n   = idx;
        dec_n   = dec_q;
        res_n   = res_q;
        f_n     = f_out;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_n     = a_in;
                    b_n     = b_in;
                    sgn_n   = signed_mode;
                    casc_n  = casc_in;
                    idx_n   = LAST;
                    dec_n   = 1'b0;
                    res_n   = '0;
                    state_n = CMP;
                end else begin
                    state_n = IDLE;
                end
            end
            CMP: begin
                dec_n = dec_now;
                res_n = res_now;
                if (idx == '0 || (EARLY_EXIT != 0 && dec_now)) begin
                    state_n = DONE;
                    f_n     = dec_now ? {res_now, 1'b0} : casc_res;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == CMP);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mag_compare.sv
// Directed bench for seq_mag_compare.
// Runs early-exit and full-scan instances side by side.
module tb_seq_mag_compare;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        sgn;
    logic [2:0]  casc;
    logic        busy1, done1, busy0, done0;
    logic [2:0]  f1, f0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic [2:0]  cc;
        logic [2:0]  exp_f;
        int          k1;
        int          k0;
    } vec_t;

    vec_t vecs[$];

    seq_mag_compare #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u_ee1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .signed_mode(sgn), .casc_in(casc),
        .busy(busy1), .done(done1), .f_out(f1)
    );

    seq_mag_compare #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u_ee0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .signed_mode(sgn), .casc_in(casc),
        .busy(busy0), .done(done0), .f_out(f0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Issue one op to both instances and measure latency/busy/result
    task automatic run_vec(input vec_t v);
        int d1, d0, n1, n0, p1, p0;
        d1 = -1; d0 = -1; n1 = 0; n0 = 0; p1 = 0; p0 = 0;
        #1;
        a_in = v.a; b_in = v.b; sgn = v.sg; casc = v.cc;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (c == 0) begin
                start = 1'b0;
                a_in  = ~v.a;
                b_in  = ~v.b;
                sgn   = ~v.sg;
                casc  = 3'b000;
            end
            if (done1) begin p1++; if (d1 < 0) d1 = c; end
            if (done0) begin p0++; if (d0 < 0) d0 = c; end
            if (busy1) n1++;
            if (busy0) n0++;
            if (c == 10) begin
                check({v.name, " f ee1"}, int'(f1), int'(v.exp_f));
                check({v.name, " f ee0"}, int'(f0), int'(v.exp_f));
            end
            @(posedge clk);
        end
        check({v.name, " lat ee1"}, d1, v.k1);
        check({v.name, " lat ee0"}, d0, v.k0);
        check({v.name, " busy ee1"}, n1, v.k1);
        check({v.name, " busy ee0"}, n0, v.k0);
        check({v.name, " pulses ee1"}, p1, 1);
        check({v.name, " pulses ee0"}, p0, 1);
    endtask

    initial begin : main
        int dn, p, lat;
        bit ok;

        vecs.push_back('{"u_1234_1235", 16'h1234, 16'h1235, 1'b0, 3'b111, 3'b010, 4, 4});
        vecs.push_back('{"u_9000_1000", 16'h9000, 16'h1000, 1'b0, 3'b111, 3'b100, 1, 4});
        vecs.push_back('{"s_9000_1000", 16'h9000, 16'h1000, 1'b1, 3'b111, 3'b010, 1, 4});
        vecs.push_back('{"s_ffff_0000", 16'hFFFF, 16'h0000, 1'b1, 3'b111, 3'b010, 1, 4});
        vecs.push_back('{"u_ffff_0000", 16'hFFFF, 16'h0000, 1'b0, 3'b111, 3'b100, 1, 4});
        vecs.push_back('{"s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, 3'b111, 3'b100, 4, 4});
        vecs.push_back('{"s_7000_8000", 16'h7000, 16'h8000, 1'b1, 3'b111, 3'b100, 1, 4});
        vecs.push_back('{"u_0050_0060", 16'h0050, 16'h0060, 1'b0, 3'b111, 3'b010, 3, 4});
        vecs.push_back('{"eq_c100", 16'hABCD, 16'hABCD, 1'b0, 3'b100, 3'b100, 4, 4});
        vecs.push_back('{"eq_c010", 16'hABCD, 16'hABCD, 1'b0, 3'b010, 3'b010, 4, 4});
        vecs.push_back('{"eq_c001", 16'hABCD, 16'hABCD, 1'b0, 3'b001, 3'b001, 4, 4});
        vecs.push_back('{"eq_c111", 16'hABCD, 16'hABCD, 1'b0, 3'b111, 3'b001, 4, 4});
        vecs.push_back('{"eq_c000", 16'hABCD, 16'hABCD, 1'b0, 3'b000, 3'b001, 4, 4});
        vecs.push_back('{"eq_c011", 16'hABCD, 16'hABCD, 1'b1, 3'b011, 3'b001, 4, 4});

        rst_n = 1'b0; start = 1'b0;
        a_in = '0; b_in = '0; sgn = 1'b0; casc = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", int'(busy1), 0);
        check("rst done", int'(done1), 0);
        check("rst f", int'(f1), 0);
        check("rst f ee0", int'(f0), 0);
        rst_n = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // start pulse while busy must be ignored
        #1;
        a_in = 16'h0001; b_in = 16'h0002; sgn = 1'b0; casc = 3'b111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        a_in = 16'hFFFF; b_in = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = -1; p = 0;
        for (int c = 3; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done1) begin p++; if (dn < 0) dn = c; end
        end
        check("ign f", int'(f1), 3'b010);
        check("ign lat", dn, 4);
        check("ign pulses", p, 1);

        // back-to-back: start held through the DONE cycle
        a_in = 16'h0001; b_in = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (done1) ok = 1'b1;
        end
        check("b2b first done", int'(ok), 1);
        check("b2b first f", int'(f1), 3'b010);
        a_in = 16'h0005; b_in = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no idle busy", int'(busy1), 1);
        check("b2b no idle done", int'(done1), 0);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (done1 && lat < 0) lat = c;
        end
        check("b2b second lat", lat, 4);
        check("b2b second f", int'(f1), 3'b100);

        // asynchronous reset in the middle of a compare
        a_in = 16'h1234; b_in = 16'h1235; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3;
        check("pre-rst busy", int'(busy1), 1);
        rst_n = 1'b0;
        #1;
        check("arst busy", int'(busy1), 0);
        check("arst done", int'(done1), 0);
        check("arst f", int'(f1), 0);
        check("arst busy ee0", int'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        p = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done1 || done0 || busy1 || busy0) p++;
        end
        check("post-rst quiet", p, 0);
        @(posedge clk);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
